// File: rtl/codec_i2c_responder.sv
// Codec-side I2C write-only target: decodes 3-byte writes {addr,W}{reg,d8}{d7:0}
// into a 10 x 9-bit register bank with codec power-on defaults.
`timescale 1ns/1ps
module codec_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       wr_strobe,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       bad_reg,
  output logic       busy
);

  localparam int unsigned CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK0, ST_BYTE1, ST_ACK1, ST_BYTE2, ST_ACK2, ST_IGNORE
  } state_t;

  function automatic logic [8:0] f_default(input int unsigned idx);
    case (idx)
      0, 1:    f_default = 9'h097;
      2, 3:    f_default = 9'h079;
      4:       f_default = 9'h00A;
      5:       f_default = 9'h008;
      6:       f_default = 9'h09F;
      7:       f_default = 9'h00A;
      default: f_default = 9'h000;
    endcase
  endfunction

  // Index 0 = SCL, 1 = SDA. Reset to the idle-bus level so release makes no edges.
  logic [1:0]    r_sync1, r_sync2, r_flt, r_flt_d;
  logic [CW-1:0] r_cnt [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_flt   <= '1;
      r_flt_d <= '1;
      for (int unsigned i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= {sda_i, scl_i};
      r_sync2 <= r_sync1;
      r_flt_d <= r_flt;
      for (int unsigned i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_flt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILT_LEN - 1)) begin
          r_flt[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic w_scl_r, w_scl_f, w_sda_r, w_sda_f, w_start, w_stop;
  assign w_scl_r = r_flt[0] & ~r_flt_d[0];
  assign w_scl_f = ~r_flt[0] & r_flt_d[0];
  assign w_sda_r = r_flt[1] & ~r_flt_d[1];
  assign w_sda_f = ~r_flt[1] & r_flt_d[1];
  // SCL level is already post-edge here, so an SCL edge in the same clk wins.
  assign w_start = w_sda_f & r_flt[0];
  assign w_stop  = w_sda_r & r_flt[0];

  state_t     r_state, w_state_nx;
  logic [2:0] r_bcnt, w_bcnt_nx;
  logic [6:0] r_shift, w_shift_nx;
  logic [7:0] r_byte1, w_byte1_nx;
  logic       r_ack_on, w_ack_nx;
  logic       w_commit;
  logic [7:0] w_byte;
  logic [6:0] w_cm_reg;
  logic [8:0] w_cm_data;

  assign w_byte    = {r_shift, r_flt[1]};
  assign w_cm_reg  = r_byte1[7:1];
  assign w_cm_data = {r_byte1[0], w_byte};

  always_comb begin
    w_state_nx = r_state;
    w_bcnt_nx  = r_bcnt;
    w_shift_nx = r_shift;
    w_byte1_nx = r_byte1;
    w_ack_nx   = r_ack_on;
    w_commit   = 1'b0;
    if (w_start) begin
      w_state_nx = ST_ADDR;
      w_bcnt_nx  = '0;
      w_ack_nx   = 1'b0;
    end else if (w_stop) begin
      w_state_nx = ST_IDLE;
      w_ack_nx   = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_BYTE1, ST_BYTE2: begin
          if (w_scl_r) begin
            w_shift_nx = w_byte[6:0];
            w_bcnt_nx  = r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) begin
              case (r_state)
                ST_ADDR:  w_state_nx = (w_byte == {DEV_ADDR, 1'b0}) ? ST_ACK0 : ST_IGNORE;
                ST_BYTE1: begin
                  w_byte1_nx = w_byte;
                  w_state_nx = ST_ACK1;
                end
                default: begin
                  w_state_nx = ST_ACK2;
                  w_commit   = 1'b1;
                end
              endcase
            end
          end
        end
        ST_ACK0, ST_ACK1, ST_ACK2: begin
          // First scl_f opens the ACK slot, the second closes it.
          if (w_scl_f) begin
            if (!r_ack_on) begin
              w_ack_nx = 1'b1;
            end else begin
              w_ack_nx  = 1'b0;
              w_bcnt_nx = '0;
              case (r_state)
                ST_ACK0: w_state_nx = ST_BYTE1;
                ST_ACK1: w_state_nx = ST_BYTE2;
                default: w_state_nx = ST_IGNORE;
              endcase
            end
          end
        end
        default: w_ack_nx = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_bcnt   <= '0;
      r_shift  <= '0;
      r_byte1  <= '0;
      r_ack_on <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_bcnt   <= w_bcnt_nx;
      r_shift  <= w_shift_nx;
      r_byte1  <= w_byte1_nx;
      r_ack_on <= w_ack_nx;
    end
  end

  logic [8:0] r_bank [10];
  logic       r_strobe, r_bad;
  logic [6:0] r_wr_addr;
  logic [8:0] r_wr_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe  <= 1'b0;
      r_bad     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int unsigned i = 0; i < 10; i++) r_bank[i] <= f_default(i);
    end else begin
      r_strobe <= 1'b0;
      r_bad    <= 1'b0;
      if (w_commit) begin
        r_strobe  <= 1'b1;
        r_wr_addr <= w_cm_reg;
        r_wr_data <= w_cm_data;
        if (w_cm_reg == 7'h0F) begin
          for (int unsigned i = 0; i < 10; i++) r_bank[i] <= f_default(i);
        end else if (w_cm_reg < 7'd10) begin
          r_bank[w_cm_reg[3:0]] <= w_cm_data;
        end else begin
          r_bad <= 1'b1;
        end
      end
    end
  end

  assign rd_data   = (rd_addr < 4'd10) ? r_bank[rd_addr] : '0;
  assign sda_oe    = r_ack_on;
  assign wr_strobe = r_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign bad_reg   = r_bad;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Bench for codec_i2c_responder: bit-banged I2C master, transaction-level bank model.
`timescale 1ns/1ps
module tb_codec_i2c_responder;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tb_scl = 1'b1;
  logic       tb_sda = 1'b1;
  logic       sda_bus;
  logic [3:0] rd_addr = '0;
  logic       sda_oe, wr_strobe, bad_reg, busy;
  logic [8:0] rd_data, wr_data;
  logic [6:0] wr_addr;

  assign sda_bus = tb_sda & ~sda_oe;
  always #10 clk = ~clk;

  codec_i2c_responder #(.DEV_ADDR(7'h1A), .FILT_LEN(3)) dut (
    .clk(clk), .rst(rst), .scl_i(tb_scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .bad_reg(bad_reg), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  logic [8:0] m_bank [10];
  logic [6:0] m_wr_addr;
  logic [8:0] m_wr_data;
  bit chk_en = 0;
  bit in_ack = 0;
  int strobe_cnt = 0;
  int bad_cnt = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_defaults();
    m_bank = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  endtask

  task automatic m_reset();
    m_defaults();
    m_wr_addr = '0;
    m_wr_data = '0;
  endtask

  // Per-cycle compare against the model while the bus is quiescent.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data", rd_data, (rd_addr < 4'd10) ? m_bank[rd_addr] : 9'h000);
      check("idle_busy", busy, 0);
      check("idle_sda_oe", sda_oe, 0);
      check("idle_strobe", wr_strobe, 0);
      check("wr_addr_hold", wr_addr, m_wr_addr);
      check("wr_data_hold", wr_data, m_wr_data);
    end
    if (rst) check("oe_while_scl_high", sda_oe & tb_scl & ~in_ack, 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      if (wr_strobe) begin
        strobe_cnt++;
        last_addr = wr_addr;
        last_data = wr_data;
      end
      if (bad_reg) begin
        bad_cnt++;
        check("bad_without_strobe", wr_strobe, 1);
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_out(input logic b);
    tb_sda = b;
    clks(Q);
    tb_scl = 1'b1;
    clks(2 * Q);
    tb_scl = 1'b0;
    clks(Q);
  endtask

  task automatic start_c();
    tb_sda = 1'b1;
    clks(Q);
    tb_scl = 1'b1;
    clks(Q);
    tb_sda = 1'b0;
    clks(Q);
    tb_scl = 1'b0;
    clks(Q);
  endtask

  task automatic stop_c();
    tb_sda = 1'b0;
    clks(Q);
    tb_scl = 1'b1;
    clks(Q);
    tb_sda = 1'b1;
    clks(3 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    tb_sda = 1'b1;
    in_ack = 1'b1;
    clks(Q);
    tb_scl = 1'b1;
    clks(Q);
    a = sda_oe;
    clks(Q);
    tb_scl = 1'b0;
    clks(Q);
    in_ack = 1'b0;
    check(nm, a, exp_ack);
  endtask

  task automatic sweep();
    chk_en = 1;
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      clks(2);
    end
    chk_en = 0;
    rd_addr = '0;
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [8:0] exp, input string nm);
    rd_addr = a;
    clks(1);
    check(nm, rd_data, exp);
  endtask

  // Expectations come from the frame-level rules: ACK only for address byte 8'h34
  // and the two following bytes; a complete 3-byte frame commits once.
  task automatic frame3(input logic [7:0] b0, b1, b2);
    logic       ack;
    logic [6:0] r;
    logic [8:0] d;
    int s0, bd0, exp_bad;
    ack = (b0 == 8'h34);
    r = b1[7:1];
    d = {b1[0], b2};
    s0 = strobe_cnt;
    bd0 = bad_cnt;
    exp_bad = 0;
    start_c();
    check("busy_after_start", busy, 1);
    send_byte(b0, ack, "ack_addr");
    send_byte(b1, ack, "ack_byte1");
    send_byte(b2, ack, "ack_byte2");
    stop_c();
    check("busy_after_stop", busy, 0);
    if (ack) begin
      m_wr_addr = r;
      m_wr_data = d;
      if (r < 7'd10) m_bank[r[3:0]] = d;
      else if (r == 7'h0F) m_defaults();
      else exp_bad = 1;
    end
    check("strobe_count", strobe_cnt - s0, ack ? 1 : 0);
    check("bad_count", bad_cnt - bd0, exp_bad);
    if (ack) begin
      check("strobe_addr", last_addr, r);
      check("strobe_data", last_data, d);
    end
    sweep();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    m_reset();
    clks(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_bad", bad_reg, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    sweep();
    rst = 1'b1;
    clks(10);

    // 1: R4 <= 012
    frame3(8'h34, 8'h08, 8'h12);
    read_lit(4'd4, 9'h012, "lit_r4");
    check("lit_addr4", last_addr, 7'h04);
    // 2: wrong address
    frame3(8'h36, 8'h08, 8'h12);
    // 3: R7 <= 1FF then restore defaults via reg 0x0F
    frame3(8'h34, 8'h0F, 8'hFF);
    read_lit(4'd7, 9'h1FF, "lit_r7_1ff");
    frame3(8'h34, 8'h1E, 8'h00);
    check("lit_addr_0f", last_addr, 7'h0F);
    read_lit(4'd7, 9'h00A, "lit_r7_default");
    read_lit(4'd4, 9'h00A, "lit_r4_default");

    // 4: read-direction address is NACKed, busy holds until STOP
    s0 = strobe_cnt;
    start_c();
    send_byte(8'h35, 1'b0, "ack_read_addr");
    send_byte(8'h08, 1'b0, "ack_ignored");
    check("busy_in_ignore", busy, 1);
    stop_c();
    check("busy_after_ignore_stop", busy, 0);
    check("strobe_read", strobe_cnt - s0, 0);
    sweep();

    // 5: repeated START mid third byte, then a full frame plus an extra byte
    s0 = strobe_cnt;
    start_c();
    send_byte(8'h34, 1'b1, "ack5_addr");
    send_byte(8'h08, 1'b1, "ack5_b1");
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b0); bit_out(1'b1);
    start_c();
    check("busy_rstart", busy, 1);
    send_byte(8'h34, 1'b1, "ack5_addr2");
    send_byte(8'h00, 1'b1, "ack5_b1_2");
    send_byte(8'h17, 1'b1, "ack5_b2_2");
    send_byte(8'h55, 1'b0, "ack5_extra");
    stop_c();
    check("strobe_rstart", strobe_cnt - s0, 1);
    check("lit_addr0", last_addr, 7'h00);
    check("lit_data017", last_data, 9'h017);
    m_bank[0] = 9'h017;
    m_wr_addr = 7'h00;
    m_wr_data = 9'h017;
    read_lit(4'd0, 9'h017, "lit_r0");
    sweep();

    // 6: async reset in the middle of the second byte
    start_c();
    send_byte(8'h34, 1'b1, "ack6_addr");
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b0); bit_out(1'b0);
    rst = 1'b0;
    #3;
    check("rst6_sda_oe", sda_oe, 0);
    check("rst6_busy", busy, 0);
    check("rst6_strobe", wr_strobe, 0);
    m_reset();
    sweep();
    tb_scl = 1'b1;
    tb_sda = 1'b1;
    clks(4);
    rst = 1'b1;
    clks(10);
    frame3(8'h34, 8'h0C, 8'h00);
    read_lit(4'd6, 9'h000, "lit_r6");
    s0 = bad_cnt;
    frame3(8'h34, 8'h16, 8'h55);
    check("lit_bad_pulse", bad_cnt - s0, 1);
    check("lit_addr_0b", last_addr, 7'h0B);
    read_lit(4'd6, 9'h000, "lit_r6_kept");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
